// File: rtl/core_config_loader_pkg.sv
// Shared types and constants for the core configuration loader.
// The optional image checksum is enabled by defining CORE_CFG_CHECKSUM_EN.
package core_cfg_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int CSUM_W         = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR_RF,
    ST_LOAD_LEN,
    ST_LOAD_WORD,
    ST_CHECK,
    ST_FINISH,
    ST_DONE,
    ST_WAIT_EXIT,
    ST_ERROR
  } state_t;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + CSUM_W'(b);
  endfunction

endpackage

// File: rtl/core_config_loader_if.sv
// Host byte link into the configuration loader.
interface core_config_loader_if;
  // A byte transfers on a rising clk edge where byte_valid and byte_ready are
  // both high; the source holds byte_data stable while byte_valid is high and
  // never waits on byte_ready before raising byte_valid.
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/core_config_loader_word_assembler.sv
// Little-endian byte-to-word shift register: the first byte lands in bits [7:0].
module cfg_word_assembler
  import core_cfg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            last_byte,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  logic [1:0]      cnt;
  logic [XLEN-1:0] shreg;

  assign last_byte = (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (in_valid) begin
        shreg <= {in_data, shreg[XLEN-1:8]};
        cnt   <= cnt + 2'd1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {in_data, shreg[XLEN-1:8]};
        end
      end
    end
  end

endmodule

// File: rtl/core_config_loader.sv
// Configuration-phase sequencer: clears scoreboard and register file, then loads
// a length-prefixed program image into instruction memory (CORE_CFG_CHECKSUM_EN adds a checksum byte).
module core_config_loader
  import core_cfg_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int NREGS   = 32,
  parameter int XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_active,
  core_config_loader_if.slave      bus,
  output logic                     sb_clear,
  output logic                     rf_clr_we,
  output logic [$clog2(NREGS)-1:0] rf_clr_addr,
  output logic                     imem_we,
  output logic [IMEM_AW-1:0]       imem_addr,
  output logic [XLEN-1:0]          imem_wdata,
  output logic                     config_done,
  output logic                     cfg_error,
  output state_t                   dbg_state
);

  localparam int RF_AW = $clog2(NREGS);
  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << IMEM_AW;
`ifdef CORE_CFG_CHECKSUM_EN
  localparam state_t END_STATE = ST_CHECK;
`else
  localparam state_t END_STATE = ST_FINISH;
`endif

  state_t            state, state_next;
  logic [RF_AW-1:0]  rf_cnt;
  logic [7:0]        len_lo;
  logic              len_idx;
  logic [CNT_W-1:0]  n_words, word_cnt, len_n;
  logic [IMEM_AW-1:0] addr_q;
  logic              err_q;
  logic              accept, asm_clear, asm_in_valid, asm_last, asm_valid;
  logic [XLEN-1:0]   asm_word;

  assign accept = bus.byte_valid & bus.byte_ready;
  assign len_n  = {1'b0, bus.byte_data, len_lo};

  // Gating with cfg_active keeps a byte from being consumed in the abort cycle.
  always_comb begin
    bus.byte_ready = 1'b0;
    case (state)
      ST_LOAD_LEN, ST_LOAD_WORD, ST_ERROR: bus.byte_ready = cfg_active;
`ifdef CORE_CFG_CHECKSUM_EN
      ST_CHECK:                            bus.byte_ready = cfg_active;
`endif
      default: ;
    endcase
  end

`ifdef CORE_CFG_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == ST_IDLE) begin
      csum <= '0;
    end else if (accept && (state == ST_LOAD_LEN || state == ST_LOAD_WORD)) begin
      csum <= csum_add(csum, bus.byte_data);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != ST_IDLE && !cfg_active) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (cfg_active) state_next = ST_CLR_RF;
        ST_CLR_RF:    if (rf_cnt == RF_AW'(NREGS - 1)) state_next = ST_LOAD_LEN;
        ST_LOAD_LEN: begin
          if (accept && len_idx == 1'(LEN_BYTES - 1)) begin
            if (len_n > MAX_WORDS)  state_next = ST_ERROR;
            else if (len_n == '0)   state_next = END_STATE;
            else                    state_next = ST_LOAD_WORD;
          end
        end
        ST_LOAD_WORD: begin
          if (accept && asm_last && (word_cnt + CNT_W'(1) == n_words))
            state_next = END_STATE;
        end
`ifdef CORE_CFG_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) state_next = (bus.byte_data == csum) ? ST_FINISH : ST_ERROR;
        end
`endif
        ST_FINISH:    state_next = ST_DONE;
        ST_DONE:      state_next = ST_WAIT_EXIT;
        ST_WAIT_EXIT: state_next = ST_WAIT_EXIT;
        ST_ERROR:     state_next = ST_ERROR;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_cnt   <= '0;
      len_lo   <= '0;
      len_idx  <= 1'b0;
      n_words  <= '0;
      word_cnt <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rf_cnt   <= '0;
          len_lo   <= '0;
          len_idx  <= 1'b0;
          n_words  <= '0;
          word_cnt <= '0;
        end
        ST_CLR_RF: rf_cnt <= (rf_cnt == RF_AW'(NREGS - 1)) ? '0 : rf_cnt + RF_AW'(1);
        ST_LOAD_LEN: begin
          if (accept) begin
            if (len_idx == 1'(LEN_BYTES - 1)) begin
              n_words <= len_n;
            end else begin
              len_lo  <= bus.byte_data;
              len_idx <= 1'b1;
            end
          end
        end
        ST_LOAD_WORD: begin
          // The address is registered alongside the assembled word.
          if (accept && asm_last) begin
            addr_q   <= word_cnt[IMEM_AW-1:0];
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_q <= 1'b0;
    else if (state == ST_IDLE && cfg_active) err_q <= 1'b0;
    else if (state_next == ST_ERROR)         err_q <= 1'b1;
  end

  assign asm_clear    = (state == ST_IDLE) | ~cfg_active;
  assign asm_in_valid = accept & (state == ST_LOAD_WORD);

  cfg_word_assembler #(.XLEN(XLEN)) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .in_valid   (asm_in_valid),
    .in_data    (bus.byte_data),
    .last_byte  (asm_last),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  assign sb_clear    = (state == ST_CLR_RF) && (rf_cnt == '0);
  assign rf_clr_we   = (state == ST_CLR_RF);
  assign rf_clr_addr = rf_cnt;
  assign imem_we     = asm_valid;
  assign imem_addr   = addr_q;
  assign imem_wdata  = asm_word;
  assign config_done = (state == ST_DONE);
  assign cfg_error   = err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_core_config_loader.sv
// Bench for core_config_loader: random images checked against a byte-stream image model.
module tb_core_config_loader;
  import core_cfg_pkg::*;

  localparam int IMEM_AW = 8;
  localparam int NREGS   = 32;
  localparam int XLEN    = 32;
  localparam int RF_AW   = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_active = 1'b0;
  logic sb_clear, rf_clr_we, imem_we, config_done, cfg_error;
  logic [RF_AW-1:0]   rf_clr_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_wdata;
  state_t             dbg_state;

  core_config_loader_if bus_if();

  core_config_loader #(.IMEM_AW(IMEM_AW), .NREGS(NREGS), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_active  (cfg_active),
    .bus         (bus_if),
    .sb_clear    (sb_clear),
    .rf_clr_we   (rf_clr_we),
    .rf_clr_addr (rf_clr_addr),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .config_done (config_done),
    .cfg_error   (cfg_error),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_fail = 0;
  int t_start;
  int acc_cyc[$];
  logic [7:0]  img_q[$];
  logic [31:0] words_q[$];

  // Monitor: event cycle = edge count + 1 (the cycle following that edge)
  int wa_q[$], wc_q[$], ca_q[$], cc_q[$], sb_q[$], done_q[$];
  logic [31:0] wd_q[$];
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(int'(imem_addr));
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc + 1);
    end
    if (config_done) done_q.push_back(cyc + 1);
    if (rf_clr_we) begin
      ca_q.push_back(int'(rf_clr_addr));
      cc_q.push_back(cyc + 1);
    end
    if (sb_clear) sb_q.push_back(cyc + 1);
  end

  // Driver tasks
  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ca_q.delete(); cc_q.delete();
    sb_q.delete(); done_q.delete(); acc_cyc.delete();
  endtask

  task automatic start_cfg();
    clear_mon();
    @(posedge clk); #1;
    cfg_active = 1'b1;
    t_start = cyc + 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  waited = 0;
    bit  ok = 0;
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = b;
    while (waited < 200) begin
      @(negedge clk);
      if (bus_if.byte_ready) begin
        @(posedge clk); #1;
        acc_cyc.push_back(cyc);
        ok = 1;
        break;
      end
      waited++;
    end
    bus_if.byte_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_byte: byte %0h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_img(input int gap, input bit rnd);
    int g;
    foreach (img_q[i]) begin
      send_byte(img_q[i]);
      g = rnd ? int'($urandom_range(0, 2)) : gap;
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic make_image();
    int n;
    n = words_q.size();
    img_q.delete();
    img_q.push_back(8'(n));
    img_q.push_back(8'(n >> 8));
    foreach (words_q[i])
      for (int b = 0; b < 4; b++) img_q.push_back(words_q[i][8*b +: 8]);
`ifdef CORE_CFG_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'h00;
      foreach (img_q[i]) s = s + img_q[i];
      img_q.push_back(s);
    end
`endif
  endtask

  task automatic random_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  // Scoreboard: model reads the byte image and derives writes, timing and error
  task automatic check_result(input string tag);
    int n, fin;
    bit err;
    logic [31:0] exp_q[$];
    repeat (6) @(posedge clk);
    #1;
    n   = int'(img_q[0]) + 256 * int'(img_q[1]);
    err = (n > (1 << IMEM_AW));
    if (!err)
      for (int i = 0; i < n; i++)
        exp_q.push_back({img_q[2+4*i+3], img_q[2+4*i+2], img_q[2+4*i+1], img_q[2+4*i]});
    fin = 2 + 4 * n - 1;
`ifdef CORE_CFG_CHECKSUM_EN
    if (!err) begin
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) s = s + img_q[i];
      fin++;
      if (img_q[fin] !== s) err = 1;
    end
`endif

    n_cmp++;
    if (ca_q.size() !== NREGS) begin
      n_fail++; $display("FAIL %s clr_count: got %0d expected %0d", tag, ca_q.size(), NREGS);
    end
    for (int i = 0; i < ca_q.size() && i < NREGS; i++) begin
      n_cmp++;
      if (ca_q[i] !== i || cc_q[i] !== t_start + 1 + i) begin
        n_fail++;
        $display("FAIL %s clr[%0d]: got addr %0d cyc %0d expected addr %0d cyc %0d",
                 tag, i, ca_q[i], cc_q[i], i, t_start + 1 + i);
      end
    end
    n_cmp++;
    if (sb_q.size() !== 1 || (sb_q.size() > 0 && sb_q[0] !== t_start + 1)) begin
      n_fail++;
      $display("FAIL %s sb_clear: got %0d pulses first %0d expected 1 at %0d", tag, sb_q.size(),
               (sb_q.size() > 0) ? sb_q[0] : -1, t_start + 1);
    end
    n_cmp++;
    if (acc_cyc.size() !== img_q.size()) begin
      n_fail++; $display("FAIL %s accepted: got %0d expected %0d", tag, acc_cyc.size(), img_q.size());
    end else begin
      n_cmp++;
      if (acc_cyc[0] !== t_start + NREGS + 1) begin
        n_fail++; $display("FAIL %s first_accept: got %0d expected %0d", tag, acc_cyc[0], t_start + NREGS + 1);
      end
    end

    n_cmp++;
    if (wa_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL %s write_count: got %0d expected %0d", tag, wa_q.size(), exp_q.size());
    end
    for (int i = 0; i < wa_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (wa_q[i] !== i || wd_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got %0h@%0d expected %0h@%0d", tag, i, wd_q[i], wa_q[i], exp_q[i], i);
      end
      if (2 + 4 * i + 3 < acc_cyc.size()) begin
        n_cmp++;
        if (wc_q[i] !== acc_cyc[2+4*i+3] + 1) begin
          n_fail++;
          $display("FAIL %s write_time[%0d]: got %0d expected %0d", tag, i, wc_q[i], acc_cyc[2+4*i+3] + 1);
        end
      end
    end

    n_cmp++;
    if (done_q.size() !== (err ? 0 : 1)) begin
      n_fail++; $display("FAIL %s done_count: got %0d expected %0d", tag, done_q.size(), err ? 0 : 1);
    end else if (!err && fin < acc_cyc.size()) begin
      n_cmp++;
      if (done_q[0] !== acc_cyc[fin] + 2) begin
        n_fail++; $display("FAIL %s done_time: got %0d expected %0d", tag, done_q[0], acc_cyc[fin] + 2);
      end
    end

    n_cmp++;
    if (cfg_error !== err) begin
      n_fail++; $display("FAIL %s cfg_error: got %0b expected %0b", tag, cfg_error, err);
    end
  endtask

  task automatic stop_cfg(input string tag);
    @(posedge clk); #1;
    cfg_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dbg_state !== ST_IDLE || bus_if.byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s exit: got state %0d ready %0b expected state %0d ready 0",
               tag, dbg_state, bus_if.byte_ready, ST_IDLE);
    end
  endtask

  task automatic run_image(input string tag, input int gap, input bit rnd);
    start_cfg();
    send_img(gap, rnd);
    check_result(tag);
    stop_cfg(tag);
  endtask

  // Scenarios
  task automatic test_reset();
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sb_clear, rf_clr_we, imem_we, config_done, cfg_error, bus_if.byte_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {sb_clear, rf_clr_we, imem_we, config_done, cfg_error, bus_if.byte_ready});
    end
    n_cmp++;
    if (rf_clr_addr !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h %0h %0h expected 0 0 0", rf_clr_addr, imem_addr, imem_wdata);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_full_image();
    words_q = '{32'h0000_0013, 32'hDEAD_BEEF, 32'h1234_5678};
    make_image();
    run_image("full_image", 0, 0);
  endtask

  task automatic test_zero_len();
    words_q.delete();
    make_image();
    run_image("zero_len", 0, 0);
  endtask

  task automatic test_overflow();
    img_q = '{8'h01, 8'h01};
    for (int i = 0; i < 5; i++) img_q.push_back(8'($urandom));
    run_image("overflow", 0, 0);
    n_cmp++;
    if (cfg_error !== 1'b1) begin
      n_fail++; $display("FAIL overflow_sticky: got %0b expected 1", cfg_error);
    end
  endtask

  task automatic test_abort();
    random_words(2);
    make_image();
    start_cfg();
    for (int i = 0; i < 7; i++) send_byte(img_q[i]);
    cfg_active = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() !== 1) begin
      n_fail++; $display("FAIL abort_writes: got %0d expected 1", wa_q.size());
    end else begin
      n_cmp++;
      if (wa_q[0] !== 0 || wd_q[0] !== words_q[0]) begin
        n_fail++; $display("FAIL abort_word0: got %0h@%0d expected %0h@0", wd_q[0], wa_q[0], words_q[0]);
      end
    end
    n_cmp++;
    if (done_q.size() !== 0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL abort_exit: got done %0d state %0d expected 0 %0d", done_q.size(), dbg_state, ST_IDLE);
    end
    random_words(3);
    make_image();
    run_image("restart", 0, 0);
  endtask

  task automatic test_gaps();
    random_words(2);
    make_image();
    run_image("gaps", 2, 0);
  endtask

  task automatic test_max_len();
    random_words(1 << IMEM_AW);
    make_image();
    run_image("max_len", 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      random_words(int'($urandom_range(1, 8)));
      make_image();
      run_image($sformatf("random%0d", k), 0, 1);
    end
  endtask

`ifdef CORE_CFG_CHECKSUM_EN
  task automatic test_checksum();
    words_q = '{32'h0102_0304};
    make_image();
    run_image("csum_good", 0, 0);
    make_image();
    img_q[img_q.size() - 1] = img_q[img_q.size() - 1] + 8'd1;
    run_image("csum_bad", 0, 0);
  endtask
`endif

  initial begin
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h00;
    test_reset();
    test_full_image();
    test_zero_len();
    test_overflow();
    test_abort();
    test_gaps();
    test_max_len();
    test_random();
`ifdef CORE_CFG_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
